// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the controller state enumeration, the architectural zero register index,
// and the default memory-wait limit used by pipeline_hazard_ctrl.
package pipeline_hazard_ctrl_pkg;

  // Binary-encoded controller states, held in a single state register.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } hz_state_e;

  // Register 0 is hard-wired to zero, so it never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default number of consecutive memory-wait cycles tolerated before timeout.
  localparam int WAIT_LIMIT_DEF = 255;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Purpose : combinational load-use comparator between the load in EX and the
//           instruction in ID.
// Ports   : ex_mem_read_i/ex_rt_i describe the EX load; id_rs_i/id_rt_i/id_uses_rt_i
//           describe the ID consumer; load_use_o flags a dependency needing one bubble.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match   = (ex_rt_i == id_rs_i);
  // Rt only counts when the ID instruction actually reads it (e.g. not for I-type dests).
  assign rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
  assign load_use_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : pipeline stall/flush controller. Freezes the pipe on data-memory waits
//           (with a sticky timeout), flushes on jumps, inserts a bubble on load-use.
// Ports   : clk/rst_n; ID/EX hazard fields; dmem_req/dmem_ready handshake;
//           Mealy enables/flush/hold outputs; stall_count (saturating); mem_timeout.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  // Wait counter only needs to reach WAIT_LIMIT; keep at least one bit.
  localparam int                 WCNT_W       = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0]  WAIT_LIMIT_C = WCNT_W'(WAIT_LIMIT);
  localparam logic [WCNT_W-1:0]  WCNT_ONE     = WCNT_W'(1);
  localparam logic [CNT_W-1:0]   STALL_MAX    = '1;
  localparam logic [CNT_W-1:0]   STALL_ONE    = CNT_W'(1);

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              timeout_q, timeout_d;

  logic              load_use;
  logic              freeze;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .load_use_o    (load_use)
  );

  // Next-state logic and Mealy output mux.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    timeout_d    = timeout_q;
    freeze       = 1'b0;

    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          wcnt_d  = WCNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          // Release cycle behaves as RUN, so a jump/load-use frozen in ID_EX is
          // evaluated now rather than lost.
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else begin
          freeze = 1'b1;
          if (wcnt_q == WAIT_LIMIT_C) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_ONE;
          end
        end
      end
      ST_TIMEOUT: begin
        // Dead until reset.
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase

    // Priority: memory freeze > jump > load-use.
    if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
    end else if (ex_jump) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Every cycle that holds the PC counts as a stall, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_count = stall_q;
  assign mem_timeout = timeout_q;

endmodule
